// File: rtl/instr_encoder_if.sv
// Field-bundle input, encoded-word output and address-base load for instr_encoder.
// The master modport is the program generator / RAM side; the slave modport is the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output base_load, base_addr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  base_load, base_addr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline packing decoded fields into
// machine words, flagging out-of-range immediates and tagging each word with a byte address.
module instr_encoder #(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic           clock,
  input logic           reset,
  instr_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_BAD6 = 3'd6,
    FMT_BAD7 = 3'd7
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  logic              r_s1_valid;
  fields_t           r_s1;
  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic              r_out_err;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_cnt;

  logic        w_s2_adv;
  logic        w_in_ready;
  logic        w_s1_load;
  logic        w_s2_load;
  logic        w_shift;
  logic [31:0] w_instr;
  logic        w_err;

  assign w_s2_adv   = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_s1_load  = bus.in_valid && w_in_ready;
  assign w_s2_load  = r_s1_valid && w_s2_adv;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_err   = r_out_err;
  assign bus.out_addr  = r_out_addr;

  // NOTE: payload registers carry no reset; they are only ever observed behind r_s1_valid.
  always_ff @(posedge clock) begin
    if (w_s1_load) begin
      r_s1.fmt    <= fmt_e'(bus.in_fmt);
      r_s1.opcode <= bus.in_opcode;
      r_s1.rd     <= bus.in_rd;
      r_s1.rs1    <= bus.in_rs1;
      r_s1.rs2    <= bus.in_rs2;
      r_s1.funct3 <= bus.in_funct3;
      r_s1.funct7 <= bus.in_funct7;
      r_s1.imm    <= bus.in_imm;
    end
  end

  assign w_shift = (r_s1.fmt == FMT_I) && (r_s1.opcode == OP_IMM) &&
                   ((r_s1.funct3 == 3'b001) || (r_s1.funct3 == 3'b101));

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    w_instr = NOP_WORD;
    w_err   = 1'b1;
    unique case (r_s1.fmt)
      FMT_R: begin
        w_instr = {r_s1.funct7, r_s1.rs2, r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
        w_err   = 1'b0;
      end
      FMT_I: begin
        if (w_shift) begin
          w_instr = {r_s1.funct7, r_s1.imm[4:0], r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
          w_err   = |r_s1.imm[31:5];
        end else begin
          w_instr = {r_s1.imm[11:0], r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
          w_err   = r_s1.imm[31:11] != {21{r_s1.imm[11]}};
        end
      end
      FMT_S: begin
        w_instr = {r_s1.imm[11:5], r_s1.rs2, r_s1.rs1, r_s1.funct3, r_s1.imm[4:0], r_s1.opcode};
        w_err   = r_s1.imm[31:11] != {21{r_s1.imm[11]}};
      end
      FMT_B: begin
        w_instr = {r_s1.imm[12], r_s1.imm[10:5], r_s1.rs2, r_s1.rs1, r_s1.funct3,
                   r_s1.imm[4:1], r_s1.imm[11], r_s1.opcode};
        w_err   = (r_s1.imm[31:12] != {20{r_s1.imm[12]}}) || r_s1.imm[0];
      end
      FMT_U: begin
        w_instr = {r_s1.imm[31:12], r_s1.rd, r_s1.opcode};
        w_err   = |r_s1.imm[11:0];
      end
      FMT_J: begin
        w_instr = {r_s1.imm[20], r_s1.imm[10:1], r_s1.imm[11], r_s1.imm[19:12],
                   r_s1.rd, r_s1.opcode};
        w_err   = (r_s1.imm[31:20] != {12{r_s1.imm[20]}}) || r_s1.imm[0];
      end
      default: begin
        w_instr = NOP_WORD;
        w_err   = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_err   <= 1'b0;
      r_out_addr  <= RESET_ADDR;
      r_cnt       <= RESET_ADDR;
    end else begin
      if (w_in_ready) r_s1_valid <= bus.in_valid;
      if (w_s2_adv) r_out_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_out_instr <= w_instr;
        r_out_err   <= w_err;
        r_out_addr  <= r_cnt;
      end
      // A coinciding base load overrides the increment; the entering word already took r_cnt.
      if (bus.base_load) r_cnt <= bus.base_addr & WORD_MASK;
      else if (w_s2_load) r_cnt <= r_cnt + WORD_STEP;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table of field bundles with hand-encoded words,
// scoreboard queue of expected words/addresses, and directed stall, address and reset sequences.
module tb_instr_encoder;
  localparam int ADDR_W = 12;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0]       instr;
    logic              err;
    logic [ADDR_W-1:0] addr;
    int                acc_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(
    .ADDR_W    (ADDR_W),
    .RESET_ADDR(12'h000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  vec_t              tbl [17];
  vec_t              cur;
  exp_t              sb_q[$];
  exp_t              e;
  logic [ADDR_W-1:0] m_addr = '0;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  bit                chk_lat = 1'b0;
  bit                have_prev = 1'b0;
  int                prev_pop = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] exp_instr, input logic exp_err);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_instr = exp_instr; v.exp_err = exp_err;
    return v;
  endfunction

  // Scoreboard: push on accepted bundle, pop and compare on each emitted word.
  always @(negedge clock) begin
    if (reset) begin
      sb_q.delete();
      m_addr = 12'h000;
      have_prev = 1'b0;
    end else begin
      if (!chk_lat) have_prev = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", bus.out_instr);
        end else begin
          e = sb_q.pop_front();
          check("instr", bus.out_instr, e.instr);
          check("err", 32'(bus.out_err), 32'(e.err));
          check("addr", 32'(bus.out_addr), 32'(e.addr));
          if (chk_lat) begin
            check("latency", cyc - e.acc_cyc, 2);
            if (have_prev) check("throughput_gap", cyc - prev_pop, 1);
            prev_pop = cyc;
            have_prev = 1'b1;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back('{instr: cur.exp_instr, err: cur.exp_err, addr: m_addr, acc_cyc: cyc});
        m_addr = m_addr + 12'd4;
      end
      if (bus.base_load) m_addr = bus.base_addr & 12'hFFC;
    end
  end

  task automatic drive(input vec_t v);
    cur           = v;
    bus.in_fmt    = v.fmt;
    bus.in_opcode = v.op;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_funct3 = v.f3;
    bus.in_funct7 = v.f7;
    bus.in_imm    = v.imm;
    bus.in_valid  = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    drive(v);
    @(negedge clock);
    while (!bus.in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("accept", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0020_81B3, 1'b0);
    tbl[1]  = mk(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0293, 1'b0);
    tbl[2]  = mk(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'h0000_0003, 32'h4030_D093, 1'b0);
    tbl[3]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0);
    tbl[4]  = mk(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0013, 1'b1);
    tbl[5]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 32'h0020_00EF, 1'b1);
    tbl[6]  = mk(3'd7, 7'h33, 5'd5, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1);
    tbl[7]  = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0);
    tbl[8]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    tbl[9]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h1234_52B7, 1'b1);
    tbl[10] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    tbl[11] = mk(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'h0000_0020, 32'h0000_9093, 1'b1);
    tbl[12] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0003, 32'h0020_8163, 1'b1);
    tbl[13] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'h8000_0063, 1'b1);
    tbl[14] = mk(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0);
    tbl[15] = mk(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
    tbl[16] = mk(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1);

    reset = 1'b1;
    cur = tbl[0];
    bus.in_valid = 1'b0;
    bus.in_fmt = '0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
    bus.out_ready = 1'b0;
    bus.base_load = 1'b0;
    bus.base_addr = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    @(posedge clock);
    #1;

    // Backpressure: two bundles fill the pipe, the third waits until the sink releases.
    send(tbl[0]);
    send(tbl[1]);
    drive(tbl[2]);
    repeat (3) begin
      @(negedge clock);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_instr", bus.out_instr, tbl[0].exp_instr);
      check("bp_hold_addr", 32'(bus.out_addr), 32'h000);
    end
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    drain();

    // Full-rate stream of the whole table.
    chk_lat = 1'b1;
    for (int i = 0; i < 17; i++) send(tbl[i]);
    bus.in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;

    // Counter wrap from a loaded base near the top of the space.
    bus.base_load = 1'b1;
    bus.base_addr = 12'hFFE;
    @(posedge clock);
    #1 bus.base_load = 1'b0;
    send(tbl[3]);
    send(tbl[8]);
    bus.in_valid = 1'b0;
    drain();

    // Base load in the same cycle the word enters S2: that word keeps the old address.
    send(tbl[7]);
    bus.in_valid  = 1'b0;
    bus.base_load = 1'b1;
    bus.base_addr = 12'h101;
    @(posedge clock);
    #1 bus.base_load = 1'b0;
    send(tbl[10]);
    bus.in_valid = 1'b0;
    drain();

    // Reset with S2 holding a stalled word and S1 full.
    bus.out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    bus.in_valid = 1'b0;
    check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    send(tbl[4]);
    bus.in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
